// File: rtl/mix_col_seq_if.sv
// mix_col_seq_if: round-controller and shared MixColumns signals of mix_col_seq (inv_i with MIX_COL_SEQ_INV_EN)
interface mix_col_seq_if;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] state_i;
  logic         last_rnd_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] state_o;
  logic [31:0]  mc_col_o;
  logic [31:0]  mc_col_i;
  logic         mc_inv_o;
  logic         busy_o;
`ifdef MIX_COL_SEQ_INV_EN
  logic         inv_i;
  modport slave (
    input  in_valid_i, state_i, last_rnd_i, out_ready_i, mc_col_i, inv_i,
    output in_ready_o, out_valid_o, state_o, mc_col_o, mc_inv_o, busy_o
  );
  modport master (
    output in_valid_i, state_i, last_rnd_i, out_ready_i, mc_col_i, inv_i,
    input  in_ready_o, out_valid_o, state_o, mc_col_o, mc_inv_o, busy_o
  );
`else
  modport slave (
    input  in_valid_i, state_i, last_rnd_i, out_ready_i, mc_col_i,
    output in_ready_o, out_valid_o, state_o, mc_col_o, mc_inv_o, busy_o
  );
  modport master (
    output in_valid_i, state_i, last_rnd_i, out_ready_i, mc_col_i,
    input  in_ready_o, out_valid_o, state_o, mc_col_o, mc_inv_o, busy_o
  );
`endif
endinterface

// File: rtl/mix_col_seq.sv
// mix_col_seq: streams one AES state through a shared 32-bit MixColumns unit column by column; MIX_COL_SEQ_INV_EN adds inverse mode
module mix_col_seq #(
  parameter int NUM_COLS = 4,
  parameter int COL_W    = 32,
  parameter int CNT_W    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mix_col_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t                      r_state, w_next;
  logic [CNT_W-1:0]            r_cnt;
  logic [NUM_COLS*COL_W-1:0]   r_buf;
  logic                        w_acc;
  logic                        w_last_col;
  logic [6:0]                  w_base;
`ifdef MIX_COL_SEQ_INV_EN
  logic                        r_inv;
`endif
  assign w_acc      = bus.in_valid_i & bus.in_ready_o;
  assign w_last_col = r_cnt == CNT_W'(NUM_COLS - 1);
  // column 0 sits in the top bits, so the slice base counts down as r_cnt counts up
  assign w_base     = {~r_cnt, 5'd0};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = (r_state == IDLE) ? (w_acc ? (bus.last_rnd_i ? DONE : RUN) : IDLE)
           : (r_state == RUN)  ? (w_last_col ? DONE : RUN)
           : (r_state == DONE) ? (bus.out_ready_i ? IDLE : DONE)
           : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_buf <= '0;
`ifdef MIX_COL_SEQ_INV_EN
      r_inv <= 1'b0;
`endif
    end else if (w_acc) begin
      r_cnt <= '0;
      r_buf <= bus.state_i;
`ifdef MIX_COL_SEQ_INV_EN
      r_inv <= bus.inv_i;
`endif
    end else if (r_state == RUN) begin
      r_cnt                  <= r_cnt + 1'b1;
      r_buf[w_base +: COL_W] <= bus.mc_col_i;
    end
  always_comb begin
    bus.in_ready_o  = r_state == IDLE;
    bus.out_valid_o = r_state == DONE;
    bus.busy_o      = r_state != IDLE;
    bus.state_o     = r_buf;
    bus.mc_col_o    = (r_state == RUN) ? r_buf[w_base +: COL_W] : '0;
`ifdef MIX_COL_SEQ_INV_EN
    bus.mc_inv_o    = (r_state == RUN) & r_inv;
`else
    bus.mc_inv_o    = 1'b0;
`endif
  end
endmodule

// File: tb/tb_mix_col_seq.sv
// tb_mix_col_seq: directed checks of mix_col_seq against a reference MixColumns unit on the shared column port
module tb_mix_col_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  mix_col_seq_if u ();
  mix_col_seq dut (.clk(clk), .rst_n(rst_n), .bus(u));
  always #5 clk = ~clk;
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [31:0] mixcol(input logic [31:0] c, input logic inv);
    logic [7:0]  a [4];
    logic [3:0]  k [4];
    logic [31:0] o;
    for (int r = 0; r < 4; r++) a[r] = c[8*(3-r) +: 8];
    if (inv) begin k[0] = 4'he; k[1] = 4'hb; k[2] = 4'hd; k[3] = 4'h9; end
    else     begin k[0] = 4'h2; k[1] = 4'h3; k[2] = 4'h1; k[3] = 4'h1; end
    o = 32'h0;
    for (int r = 0; r < 4; r++)
      o[8*(3-r) +: 8] = gm(a[r], k[0]) ^ gm(a[(r+1)%4], k[1]) ^ gm(a[(r+2)%4], k[2]) ^ gm(a[(r+3)%4], k[3]);
    return o;
  endfunction
  assign u.mc_col_i = mixcol(u.mc_col_o, u.mc_inv_o);
  localparam logic [127:0] V_FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V_FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V_BYP     = 128'hd4d4d4d5_00112233_44556677_8899aabb;
  localparam logic [127:0] V_D4_IN   = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
  localparam logic [127:0] V_D4_OUT  = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;
  localparam logic [127:0] V_SW_IN   = 128'hf20a225c_db135345_c6c6c6c6_01010101;
  localparam logic [127:0] V_SW_OUT  = 128'h9fdc589d_8e4da1bc_c6c6c6c6_01010101;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [127:0] v, input logic last, input logic iv,
                      output int lat, output logic [127:0] res, output logic [31:0] cols, output int invbad);
    u.state_i    = v;
    u.last_rnd_i = last;
`ifdef MIX_COL_SEQ_INV_EN
    u.inv_i      = iv;
`endif
    u.in_valid_i = 1'b1;
    cols   = 32'h0;
    invbad = 0;
    for (lat = 1; lat <= 20; lat++) begin
      tick;
      u.in_valid_i = 1'b0;
      cols = cols | u.mc_col_o;
      if (u.mc_inv_o !== (iv & u.busy_o & ~u.out_valid_o)) invbad++;
      if (u.out_valid_o) break;
    end
    res = u.state_o;
  endtask
  task automatic release_out(input string name);
    u.out_ready_i = 1'b1;
    tick;
    u.out_ready_i = 1'b0;
    total++;
    if (u.out_valid_o !== 1'b0 || u.in_ready_o !== 1'b1 || u.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: got valid=%b ready=%b busy=%b want 0 1 0", name, u.out_valid_o, u.in_ready_o, u.busy_o);
    end
  endtask
  task automatic test_reset;
    u.in_valid_i  = 1'b0;
    u.out_ready_i = 1'b0;
    u.last_rnd_i  = 1'b0;
    u.state_i     = '0;
`ifdef MIX_COL_SEQ_INV_EN
    u.inv_i       = 1'b0;
`endif
    rst_n = 1'b0;
    tick;
    tick;
    total++;
    if ({u.in_ready_o, u.out_valid_o, u.busy_o, u.mc_inv_o} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_ctl: got rdy/vld/busy/inv=%b want 1000", {u.in_ready_o, u.out_valid_o, u.busy_o, u.mc_inv_o});
    end
    total++;
    if (u.mc_col_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_mc_col: got %h want 0", u.mc_col_o);
    end
    total++;
    if (u.state_o !== 128'h0) begin
      bad++;
      $display("FAIL reset_state: got %h want 0", u.state_o);
    end
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_forward;
    int lat, ib;
    logic [127:0] res;
    logic [31:0] cols;
    send(V_FWD_IN, 1'b0, 1'b0, lat, res, cols, ib);
    total++;
    if (lat != 5) begin bad++; $display("FAIL fwd_latency: got %0d want 5", lat); end
    total++;
    if (res !== V_FWD_OUT) begin bad++; $display("FAIL fwd_state: got %h want %h", res, V_FWD_OUT); end
    total++;
    if (cols == 32'h0) begin bad++; $display("FAIL fwd_mc_col: got %h want nonzero", cols); end
    total++;
    if (ib != 0) begin bad++; $display("FAIL fwd_mc_inv: got %0d bad cycles want 0", ib); end
    release_out("fwd");
  endtask
  task automatic test_bypass;
    int lat, ib;
    logic [127:0] res;
    logic [31:0] cols;
    send(V_BYP, 1'b1, 1'b0, lat, res, cols, ib);
    total++;
    if (lat != 1) begin bad++; $display("FAIL byp_latency: got %0d want 1", lat); end
    total++;
    if (res !== V_BYP) begin bad++; $display("FAIL byp_state: got %h want %h", res, V_BYP); end
    total++;
    if (cols !== 32'h0) begin bad++; $display("FAIL byp_mc_col: got %h want 0", cols); end
    release_out("byp");
  endtask
  task automatic test_backpressure;
    int lat, ib;
    logic [127:0] res;
    logic [31:0] cols;
    send(V_FWD_IN, 1'b0, 1'b0, lat, res, cols, ib);
    u.state_i    = V_BYP;
    u.last_rnd_i = 1'b1;
    u.in_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      total++;
      if (u.out_valid_o !== 1'b1 || u.in_ready_o !== 1'b0 || u.state_o !== V_FWD_OUT) begin
        bad++;
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b state=%h want 1 0 %h", i, u.out_valid_o, u.in_ready_o, u.state_o, V_FWD_OUT);
      end
    end
    u.in_valid_i = 1'b0;
    u.last_rnd_i = 1'b0;
    release_out("bp");
    tick;
    total++;
    if (u.busy_o !== 1'b0 || u.state_o !== V_FWD_OUT) begin
      bad++;
      $display("FAIL bp_no_accept: got busy=%b state=%h want 0 %h", u.busy_o, u.state_o, V_FWD_OUT);
    end
  endtask
  task automatic test_async_reset;
    int lat, ib;
    logic [127:0] res;
    logic [31:0] cols;
    u.state_i    = V_FWD_IN;
    u.last_rnd_i = 1'b0;
    u.in_valid_i = 1'b1;
    tick;
    u.in_valid_i = 1'b0;
    tick;
    tick;
    total++;
    if (u.busy_o !== 1'b1 || u.mc_col_o !== 32'h01010101) begin
      bad++;
      $display("FAIL ar_col2: got busy=%b col=%h want 1 01010101", u.busy_o, u.mc_col_o);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({u.in_ready_o, u.out_valid_o, u.busy_o, u.mc_inv_o} !== 4'b1000 || u.mc_col_o !== 32'h0) begin
      bad++;
      $display("FAIL ar_outputs: got rdy/vld/busy/inv=%b col=%h want 1000 0",
               {u.in_ready_o, u.out_valid_o, u.busy_o, u.mc_inv_o}, u.mc_col_o);
    end
    #1 rst_n = 1'b1;
    tick;
    send(V_D4_IN, 1'b0, 1'b0, lat, res, cols, ib);
    total++;
    if (lat != 5 || res !== V_D4_OUT) begin
      bad++;
      $display("FAIL ar_next: got lat=%0d state=%h want 5 %h", lat, res, V_D4_OUT);
    end
    release_out("ar");
  endtask
  task automatic test_back_to_back;
    logic [127:0] vin [3];
    logic [127:0] vex [3];
    int at [3];
    int ai, oi;
    logic acc;
    vin[0] = V_FWD_IN; vex[0] = V_FWD_OUT;
    vin[1] = V_D4_IN;  vex[1] = V_D4_OUT;
    vin[2] = V_SW_IN;  vex[2] = V_SW_OUT;
    at[0] = 0; at[1] = 0; at[2] = 0;
    ai = 0;
    oi = 0;
    u.out_ready_i = 1'b1;
    u.last_rnd_i  = 1'b0;
    u.state_i     = vin[0];
    u.in_valid_i  = 1'b1;
    for (int cyc = 1; cyc <= 60 && oi < 3; cyc++) begin
      if (u.out_valid_o) begin
        total++;
        if (u.state_o !== vex[oi]) begin
          bad++;
          $display("FAIL b2b_out%0d: got %h want %h", oi, u.state_o, vex[oi]);
        end
        oi++;
      end
      acc = u.in_ready_o & u.in_valid_i;
      tick;
      if (acc) begin
        at[ai] = cyc;
        ai++;
        if (ai < 3) u.state_i = vin[ai];
        else u.in_valid_i = 1'b0;
      end
    end
    u.out_ready_i = 1'b0;
    u.in_valid_i  = 1'b0;
    total++;
    if (oi != 3 || ai != 3) begin bad++; $display("FAIL b2b_count: got acc=%0d out=%0d want 3 3", ai, oi); end
    total++;
    if (at[1] - at[0] != 6 || at[2] - at[1] != 6) begin
      bad++;
      $display("FAIL b2b_spacing: got %0d %0d want 6 6", at[1] - at[0], at[2] - at[1]);
    end
    tick;
  endtask
`ifdef MIX_COL_SEQ_INV_EN
  task automatic test_inverse;
    int lat, ib;
    logic [127:0] res;
    logic [31:0] cols;
    send(V_FWD_OUT, 1'b0, 1'b1, lat, res, cols, ib);
    total++;
    if (lat != 5 || res !== V_FWD_IN) begin
      bad++;
      $display("FAIL inv_state: got lat=%0d state=%h want 5 %h", lat, res, V_FWD_IN);
    end
    total++;
    if (ib != 0) begin bad++; $display("FAIL inv_mc_inv: got %0d bad cycles want 0", ib); end
    release_out("inv");
    u.inv_i = 1'b0;
  endtask
`endif
  initial begin
    test_reset;
    test_forward;
    test_bypass;
    test_backpressure;
    test_async_reset;
    test_back_to_back;
`ifdef MIX_COL_SEQ_INV_EN
    test_inverse;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
